imem_access_ctrl: RTL
=====================

# imem_access_ctrl

Controller that sequences and shares the byte-wide, 256-entry instruction memory between the core's fetch port and the program loader's byte-write port. A fetch is serviced as an atomic burst of four single-byte reads, assembled into one little-endian 32-bit instruction word. Loader writes are single-cycle byte stores. The block sits between the fetch stage and the single-port instruction SRAM; all memory traffic goes through it.

## Interface
Parameters:
- ADDR_W, 8, byte address width of the instruction memory (depth 2**ADDR_W)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- fetch_valid  in  1  fetch request
- fetch_ready  out  1  fetch request accepted when valid&&ready
- fetch_addr  in  32  byte address of instruction word
- rsp_valid  out  1  one-cycle pulse: response data valid
- rsp_data  out  32  assembled instruction {b3,b2,b1,b0}
- rsp_err  out  1  qualifies rsp_valid: misaligned or out-of-range fetch
- ld_valid  in  1  loader byte-write request
- ld_ready  out  1  write accepted when valid&&ready
- ld_addr  in  ADDR_W  byte address
- ld_data  in  8  byte to write
- mem_addr  out  ADDR_W  SRAM address
- mem_we  out  1  SRAM write enable
- mem_wdata  out  8  SRAM write data
- mem_rdata  in  8  SRAM read data, registered: valid one cycle after address

## Operation
- States: IDLE, FETCH (byte counter cnt 0..3), FDRAIN, WRITE, ERR.
- Requests are accepted only in IDLE; fetch_ready/ld_ready are 0 in every other state.
- Arbitration in IDLE:
  - If only one request is valid, it is granted.
  - If both are valid, grant goes to the requester not granted last (last_grant flag). The flag resets to "loader", so fetch wins the first conflict.
  - Ready outputs are combinational from the valids and the state.
- Fetch accept:
  - If fetch_addr[1:0]!=0 or fetch_addr[31:ADDR_W]!=0: go to ERR.
  - Otherwise latch base=fetch_addr[ADDR_W-1:0] and go to FETCH with cnt=0.
- FETCH: mem_addr=base+cnt, cnt increments. From cnt=3 go to FDRAIN. Byte (cnt-1) is captured from mem_rdata each cycle after the first.
- FDRAIN: capture byte 3, register rsp_valid=1, rsp_err=0, rsp_data, then go to IDLE.
- ERR: register rsp_valid=1, rsp_err=1, rsp_data=32'h00000013 (NOP), then go to IDLE. No memory access.
- Loader accept: go to WRITE. In WRITE: mem_we=1, mem_addr=ld_addr latched, mem_wdata=ld_data latched. Next state IDLE.
- Address wrap: cannot occur for in-range aligned fetches. base+cnt uses ADDR_W-bit arithmetic.
- mem_we is asserted only in WRITE. mem_addr is 0 in IDLE and ERR.
- rsp_data holds its value until the next response. rsp_valid is high for exactly one cycle per accepted fetch.
- Reset, asynchronous, any time:
  - state IDLE; all outputs 0, including rsp_data=0, rsp_err=0, mem_we=0; last_grant=loader.
  - An in-flight fetch is dropped and produces no response. An in-flight write completes only if its WRITE edge precedes reset assertion.

## Timing
- Fetch accepted at edge E0. mem_addr=base+k is driven in the cycle after E(k). Byte k is captured at E(k+2).
- rsp_valid is high in the cycle following E5, giving 5-cycle latency. fetch_ready rises in that same cycle, so the next fetch is accepted earliest at E6. Throughput is one word per 6 cycles.
- Error fetch: rsp_valid in the cycle after E1.
- Loader write accepted at E0: SRAM write at E1. ld_ready is available again after E1, so a 2-cycle write cadence is possible.
- A loader request arriving during a fetch burst waits. It is granted at the next IDLE and is never lost while ld_valid is held.

## Structure
- Shared package imem_pkg:
  - state enum imem_state_e
  - IMEM_ADDR_W=8
  - NOP_INSTR=32'h00000013
  - FETCH_BYTES=4
- Sub-module rr_arb2: two-requester round-robin arbiter with a last-grant register, reused for the later data-memory port.

## Test plan
- Preload bytes 0x04..0x07 = 13,05,10,00. Fetch 0x04 → rsp_valid exactly 5 cycles after accept, rsp_data=32'h00100513, rsp_err=0.
- Fetch 0x06 (misaligned) and fetch 0x100 (out of range) → each gives rsp_valid 1 cycle after accept, rsp_err=1, rsp_data=32'h00000013, mem_addr never leaves 0.
- Loader writes 0xAA to 0x10, then fetch 0x10 → byte0 of rsp_data = 0xAA; exactly one mem_we pulse, at the cycle after ld accept.
- fetch_valid and ld_valid held together for 4 grants → order fetch, loader, fetch, loader. No write happens mid-burst (mem_we=0 throughout FETCH/FDRAIN).
- Assert reset at cnt=2 of a fetch → all outputs 0 immediately, no rsp_valid afterwards. A fresh fetch after release returns the correct word.
- Back-to-back fetches with fetch_valid held → accepts spaced 6 cycles apart, one rsp_valid pulse per accept.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory access path.
// Used by the fetch/loader controller and its arbiter.
package imem_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam int FETCH_BYTES = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FDRAIN,
        S_WRITE,
        S_ERR
    } imem_state_e;

    // Aligned word address whose upper bits fit the memory depth
    function automatic logic fetch_addr_ok(
        input logic [31:0] addr,
        input int unsigned addr_w
    );
        return (addr[1:0] == 2'b00) && ((addr >> addr_w) == 32'd0);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a last-grant register.
// Requester b is treated as last granted out of reset, so a wins first.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    logic last_b;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (en) begin
            if (req_a && req_b) begin
                gnt_a = last_b;
                gnt_b = !last_b;
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_b <= 1'b1;
        end else if (gnt_a) begin
            last_b <= 1'b0;
        end else if (gnt_b) begin
            last_b <= 1'b1;
        end
    end

endmodule

// File: rtl/imem_access_ctrl.sv
// Shares the byte-wide instruction SRAM between fetch bursts and
// single-byte loader writes; fetches assemble a little-endian word.
module imem_access_ctrl
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_valid,
    output logic              fetch_ready,
    input  logic [31:0]       fetch_addr,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    imem_state_e state_q;
    imem_state_e state_d;

    logic [1:0]        cnt_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] ld_addr_q;
    logic [7:0]        ld_data_q;
    logic [23:0]       buf_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [31:0]       rsp_data_q;

    logic idle;
    logic gnt_f;
    logic gnt_l;
    logic addr_ok;

    assign idle = (state_q == S_IDLE);
    assign addr_ok = fetch_addr_ok(fetch_addr, ADDR_W);

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (idle),
        .req_a (fetch_valid),
        .req_b (ld_valid),
        .gnt_a (gnt_f),
        .gnt_b (gnt_l)
    );

    // Readies are forced low while reset is held so every output reads 0
    assign fetch_ready = gnt_f && !reset;
    assign ld_ready    = gnt_l && !reset;

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;

    always_comb begin
        state_d   = state_q;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_f) begin
                    state_d = addr_ok ? S_FETCH : S_ERR;
                end else if (gnt_l) begin
                    state_d = S_WRITE;
                end
            end
            S_FETCH: begin
                mem_addr = base_q + ADDR_W'(cnt_q);
                if (cnt_q == 2'(FETCH_BYTES - 1)) begin
                    state_d = S_FDRAIN;
                end
            end
            S_FDRAIN: begin
                state_d = S_IDLE;
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = ld_addr_q;
                mem_wdata = ld_data_q;
                state_d   = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            base_q      <= '0;
            ld_addr_q   <= '0;
            ld_data_q   <= 8'h00;
            buf_q       <= 24'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    cnt_q <= 2'd0;
                    if (gnt_f) begin
                        base_q <= fetch_addr[ADDR_W-1:0];
                    end else if (gnt_l) begin
                        ld_addr_q <= ld_addr;
                        ld_data_q <= ld_data;
                    end
                end
                S_FETCH: begin
                    cnt_q <= cnt_q + 2'd1;
                    // read data lags the address by one cycle
                    if (cnt_q != 2'd0) begin
                        buf_q <= {mem_rdata, buf_q[23:8]};
                    end
                end
                S_FDRAIN: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= {mem_rdata, buf_q};
                end
                S_ERR: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    rsp_data_q  <= NOP_INSTR;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
